coor_rotate: RTL and testbench
==============================

Name: coor_rotate

Overview:
- Inverse-mapping coordinate rotator that sits directly downstream of the cos lookup table.
- Takes the destination pixel coordinate stream (x, y) and the frame's rotation angle in degrees.
- Drives two table lookups: one for cos and one for sin, where sin(a) = cos(a-90).
- Computes source coordinates about the image centre and emits them, with an in-image flag, to the pixel fetch stage through a 3-stage valid/ready pipeline.

Parameters:
- IMG_W, 640, image width in pixels; valid source x is 0..IMG_W-1.
- IMG_H, 480, image height in pixels; valid source y is 0..IMG_H-1.
- CX, 320, rotation centre x.
- CY, 240, rotation centre y.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset: asynchronous, active-high.
- angle_in  in  10  requested angle, 0..359 degrees.
- frame_start  in  1  one-cycle pulse; latches angle_in into the shadow register.
- cos_angle  out  10  index to the cos table instance.
- cos_value  in  10 signed  Q2.8 cos, combinational return for cos_angle.
- sin_angle  out  10  index to the second table instance.
- sin_value  in  10 signed  Q2.8 return for sin_angle.
- in_valid  in  1  input coordinate valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- in_x  in  11  destination x, unsigned.
- in_y  in  11  destination y, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- src_x  out  11  source x; 0 when out of image.
- src_y  out  11  source y; 0 when out of image.
- src_inside  out  1  1 when (src_x, src_y) lies inside IMG_W x IMG_H.

Behaviour:
- Reset values:
  - angle shadow = 0, so cos_angle = 0 and sin_angle = 270.
  - All stage valids = 0, so out_valid = 0.
  - src_x = 0, src_y = 0, src_inside = 0.
- Angle shadow:
  - Loaded on a clk edge where frame_start = 1 and angle_in <= 359.
  - angle_in >= 360 is ignored; the shadow holds its old value.
  - cos_angle and sin_angle are registered from the shadow, one cycle after the load.
  - sin_angle = shadow + 270 if shadow < 90, else shadow - 90.
- Pipeline enable: en = !out_valid || out_ready, and in_ready = en. All stages advance together when en = 1 and freeze (data and valid held) when en = 0.
- S1:
  - dx = in_x - CX, dy = in_y - CY, 12-bit signed.
  - Captures cos_value and sin_value.
- S2:
  - px = dx*cos + dy*sin.
  - py = dy*cos - dx*sin.
  - Full-precision signed, 23 bits.
- S3:
  - sx = ((px + 128) >>> 8) + CX; sy likewise with CY. 14-bit signed, round half up.
  - src_inside = (0 <= sx < IMG_W) && (0 <= sy < IMG_H).
  - If src_inside, src_x/src_y = sx/sy[10:0]; otherwise both are 0.
- Latency: 3 clk from an accepted input to out_valid with no stall. Throughput is 1 per clk.
- Ordering is preserved and no beats are dropped or duplicated under any out_ready pattern.
- Angle change mid-frame: beats already in S1..S3 keep the coefficients they captured. Beats entering S1 one cycle after the shadow update use the new angle.
- frame_start together with in_valid in the same cycle: that beat uses the old angle.
- Reset asserted mid-operation: all in-flight beats are discarded immediately (async), outputs return to reset values, and no partial result is emitted after release.

Optional Feature:
- Macro: COOR_FRAC_EN.
- Defined:
  - Adds outputs src_x_frac and src_y_frac (8 bits each): px[7:0] and py[7:0] of the unrounded products.
  - Integer parts use floor (px >>> 8, no +128) for bilinear interpolation downstream.
  - Fractions are 0 when src_inside = 0.
  - The fractions travel with the beat, so latency is unchanged.
- Undefined: no fraction ports; integer parts are round-half-up as above.

Test Plan:
- Angle 0 (cos 256, sin 0), input (100,50) -> after exactly 3 clk: (100,50), inside = 1. A stream of 640 beats on row 0 returns identity with no gaps.
- Angle 90 (cos 0, sin 256), input (100,50) -> (130,460), inside = 1.
- Angle 180 (cos -256, sin 0), input (0,0) -> sx = 640, so inside = 0 and src_x = src_y = 0. Input (1,1) -> (639,479), inside = 1.
- Backpressure: hold out_ready = 0 for 5 clk during a 10-beat burst -> in_ready falls the same cycle, out_valid and data hold stable, and all 10 results appear in order.
- Angle control:
  - frame_start with angle_in = 400 -> shadow unchanged and cos_angle unchanged.
  - frame_start with angle_in = 45 -> next clk cos_angle = 45, sin_angle = 315.
  - Beats already in flight keep the old result.
- Assert rst for 1 clk with 3 beats in flight -> out_valid = 0 immediately. After release, no stale output appears and cos_angle = 0, sin_angle = 270.

Source files
------------

// File: rtl/coor_rotate.sv
// Inverse-mapping coordinate rotator: turns destination pixels into source coordinates about (CX, CY).
// Optional COOR_FRAC_EN adds 8-bit fractional outputs and switches the integer parts to floor.
module coor_rotate #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int CX    = 320,
   parameter int CY    = 240
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [9:0]        angle_in,
   input  logic              frame_start,
   output logic [9:0]        cos_angle,
   input  logic signed [9:0] cos_value,
   output logic [9:0]        sin_angle,
   input  logic signed [9:0] sin_value,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [10:0]       in_x,
   input  logic [10:0]       in_y,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [10:0]       src_x,
   output logic [10:0]       src_y,
   output logic              src_inside
`ifdef COOR_FRAC_EN
   ,
   output logic [7:0]        src_x_frac,
   output logic [7:0]        src_y_frac
`endif
);

   localparam logic signed [11:0] CX12  = 12'(CX);
   localparam logic signed [11:0] CY12  = 12'(CY);
   localparam logic signed [13:0] CX14  = 14'(CX);
   localparam logic signed [13:0] CY14  = 14'(CY);
   localparam logic signed [13:0] IMGW14 = 14'(IMG_W);
   localparam logic signed [13:0] IMGH14 = 14'(IMG_H);

   // Q8 product back to integer pixels, re-centred.
   function automatic logic signed [13:0] to_int(input logic signed [22:0] p,
                                                 input logic signed [13:0] ctr);
`ifdef COOR_FRAC_EN
      return 14'(p >>> 8) + ctr;
`else
      return 14'((p + 23'sd128) >>> 8) + ctr;
`endif
   endfunction

   function automatic logic in_range(input logic signed [13:0] v,
                                     input logic signed [13:0] lim);
      return (v >= 14'sd0) && (v < lim);
   endfunction

   logic [9:0] angle_q, angle_d;
   logic [9:0] cos_angle_q, sin_angle_q, sin_angle_d;
   logic       en;

   logic              vld_p1_q, vld_p2_q, vld_p3_q;
   logic signed [11:0] dx_d, dy_d, dx_p1_q, dy_p1_q;
   logic signed [9:0]  cos_p1_q, sin_p1_q;
   logic signed [21:0] m_xc, m_ys, m_yc, m_xs;
   logic signed [22:0] px_d, py_d, px_p2_q, py_p2_q;
   logic signed [13:0] sx_d, sy_d;
   logic               inside_d, inside_q;
   logic [10:0]        src_x_d, src_y_d, src_x_q, src_y_q;

   always_comb begin
      angle_d = angle_q;
      if (frame_start && (angle_in <= 10'd359))
         angle_d = angle_in;
      sin_angle_d = (angle_q < 10'd90) ? angle_q + 10'd270 : angle_q - 10'd90;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         angle_q     <= '0;
         cos_angle_q <= '0;
         sin_angle_q <= 10'd270;
      end else begin
         angle_q     <= angle_d;
         cos_angle_q <= angle_q;
         sin_angle_q <= sin_angle_d;
      end
   end

   assign cos_angle = cos_angle_q;
   assign sin_angle = sin_angle_q;
   assign en        = !vld_p3_q || out_ready;
   assign in_ready  = en;

   // S1: centre the destination coordinate and capture the table returns
   assign dx_d = signed'({1'b0, in_x}) - CX12;
   assign dy_d = signed'({1'b0, in_y}) - CY12;

   // S2: rotate, full precision
   assign m_xc = dx_p1_q * cos_p1_q;
   assign m_ys = dy_p1_q * sin_p1_q;
   assign m_yc = dy_p1_q * cos_p1_q;
   assign m_xs = dx_p1_q * sin_p1_q;
   assign px_d = {m_xc[21], m_xc} + {m_ys[21], m_ys};
   assign py_d = {m_yc[21], m_yc} - {m_xs[21], m_xs};

   // S3: back to pixels, bounds check, zero out-of-image results
   assign sx_d     = to_int(px_p2_q, CX14);
   assign sy_d     = to_int(py_p2_q, CY14);
   assign inside_d = in_range(sx_d, IMGW14) && in_range(sy_d, IMGH14);
   assign src_x_d  = inside_d ? sx_d[10:0] : 11'd0;
   assign src_y_d  = inside_d ? sy_d[10:0] : 11'd0;

   always_ff @(posedge clk) begin
      if (en) begin
         dx_p1_q  <= dx_d;
         dy_p1_q  <= dy_d;
         cos_p1_q <= cos_value;
         sin_p1_q <= sin_value;
         px_p2_q  <= px_d;
         py_p2_q  <= py_d;
      end
   end

`ifdef COOR_FRAC_EN
   logic [7:0] fx_q, fy_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         vld_p3_q <= 1'b0;
         src_x_q  <= '0;
         src_y_q  <= '0;
         inside_q <= 1'b0;
`ifdef COOR_FRAC_EN
         fx_q     <= '0;
         fy_q     <= '0;
`endif
      end else if (en) begin
         vld_p1_q <= in_valid;
         vld_p2_q <= vld_p1_q;
         vld_p3_q <= vld_p2_q;
         if (vld_p2_q) begin
            src_x_q  <= src_x_d;
            src_y_q  <= src_y_d;
            inside_q <= inside_d;
`ifdef COOR_FRAC_EN
            fx_q     <= inside_d ? px_p2_q[7:0] : 8'd0;
            fy_q     <= inside_d ? py_p2_q[7:0] : 8'd0;
`endif
         end
      end
   end

   assign out_valid  = vld_p3_q;
   assign src_x      = src_x_q;
   assign src_y      = src_y_q;
   assign src_inside = inside_q;
`ifdef COOR_FRAC_EN
   assign src_x_frac = fx_q;
   assign src_y_frac = fy_q;
`endif

endmodule

// File: tb/tb_coor_rotate.sv
// Directed bench for coor_rotate with a scoreboard of model-computed results.
module tb_coor_rotate;

   localparam int IMG_W = 640;
   localparam int IMG_H = 480;
   localparam int CX    = 320;
   localparam int CY    = 240;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [9:0]        angle_in = '0;
   logic              frame_start = 1'b0;
   logic [9:0]        cos_angle, sin_angle;
   logic signed [9:0] cos_value, sin_value;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [10:0]       in_x = '0, in_y = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [10:0]       src_x, src_y;
   logic              src_inside;
`ifdef COOR_FRAC_EN
   logic [7:0]        src_x_frac, src_y_frac;
`endif

   typedef struct {
      int sx;
      int sy;
      int ins;
      int fx;
      int fy;
   } exp_t;

   exp_t q[$];
   int   pop_cyc[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   coef_ang = 0;
   exp_t mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   coor_rotate #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CX(CX), .CY(CY)) dut (
      .clk(clk), .rst(rst), .angle_in(angle_in), .frame_start(frame_start),
      .cos_angle(cos_angle), .cos_value(cos_value),
      .sin_angle(sin_angle), .sin_value(sin_value),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
      .out_valid(out_valid), .out_ready(out_ready),
      .src_x(src_x), .src_y(src_y), .src_inside(src_inside)
`ifdef COOR_FRAC_EN
      , .src_x_frac(src_x_frac), .src_y_frac(src_y_frac)
`endif
   );

   // Cos table in Q2.8, rounded to nearest.
   function automatic int tbl(input int a);
      real r;
      r = 256.0 * $cos(real'(a) * 3.141592653589793 / 180.0);
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
   endfunction

   assign cos_value = 10'(tbl(int'(cos_angle)));
   assign sin_value = 10'(tbl(int'(sin_angle)));

   function automatic exp_t model(input int x, input int y, input int ang);
      exp_t e;
      int c, s, dx, dy, px, py, sx, sy;
      c  = tbl(ang);
      s  = tbl((ang + 270) % 360);
      dx = x - CX;
      dy = y - CY;
      px = dx * c + dy * s;
      py = dy * c - dx * s;
`ifdef COOR_FRAC_EN
      sx = (px >>> 8) + CX;
      sy = (py >>> 8) + CY;
`else
      sx = ((px + 128) >>> 8) + CX;
      sy = ((py + 128) >>> 8) + CY;
`endif
      e.ins = (sx >= 0 && sx < IMG_W && sy >= 0 && sy < IMG_H) ? 1 : 0;
      e.sx  = e.ins ? sx : 0;
      e.sy  = e.ins ? sy : 0;
      e.fx  = e.ins ? (px & 255) : 0;
      e.fy  = e.ins ? (py & 255) : 0;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         chk("out_expected_present", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            mon_e = q.pop_front();
            chk("src_x", 32'(src_x), mon_e.sx);
            chk("src_y", 32'(src_y), mon_e.sy);
            chk("src_inside", 32'(src_inside), mon_e.ins);
`ifdef COOR_FRAC_EN
            chk("src_x_frac", 32'(src_x_frac), mon_e.fx);
            chk("src_y_frac", 32'(src_y_frac), mon_e.fy);
`endif
            pop_cyc.push_back(cyc);
         end
      end
   end

   task automatic send(input int x, input int y);
      bit done;
      done = 1'b0;
      in_valid = 1'b1;
      in_x = 11'(x);
      in_y = 11'(y);
      for (int t = 0; t < 100 && !done; t++) begin
         @(negedge clk);
         if (in_ready) begin
            q.push_back(model(x, y, coef_ang));
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("send_accepted", 32'(done), 32'd1);
   endtask

   task automatic drain();
      for (int t = 0; t < 200 && q.size() != 0; t++) @(posedge clk);
      #1;
      chk("drain_empty", 32'(q.size()), 32'd0);
   endtask

   task automatic set_angle(input int a);
      int exp_ang;
      exp_ang = (a <= 359) ? a : coef_ang;
      frame_start = 1'b1;
      angle_in = 10'(a);
      @(posedge clk); #1;
      frame_start = 1'b0;
      @(posedge clk); #1;
      chk("cos_angle", 32'(cos_angle), exp_ang);
      chk("sin_angle", 32'(sin_angle), (exp_ang + 270) % 360);
      coef_ang = exp_ang;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cos_angle", 32'(cos_angle), 32'd0);
      chk("rst_sin_angle", 32'(sin_angle), 32'd270);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_src_x", 32'(src_x), 32'd0);
      chk("rst_src_y", 32'(src_y), 32'd0);
      chk("rst_src_inside", 32'(src_inside), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // angle 0, exact 3-cycle latency
      send(100, 50);
      chk("lat_c1", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_c2", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_c3", 32'(out_valid), 32'd1);
      chk("lat_x", 32'(src_x), 32'd100);
      chk("lat_y", 32'(src_y), 32'd50);
      drain();

      // identity stream along row 0, no gaps
      pop_cyc.delete();
      for (int x = 0; x < IMG_W; x++) send(x, 0);
      drain();
      chk("row0_count", 32'(pop_cyc.size()), 32'(IMG_W));
      if (pop_cyc.size() == IMG_W)
         chk("row0_no_gaps", 32'(pop_cyc[IMG_W-1] - pop_cyc[0]), 32'(IMG_W - 1));

      // angle 90
      set_angle(90);
      send(100, 50);
      drain();

      // angle 180: out-of-image edge and the last inside pixel
      set_angle(180);
      send(0, 0);
      send(1, 1);
      drain();

      // backpressure: 10-beat burst with out_ready low for 5 cycles
      pop_cyc.delete();
      begin
         int i;
         i = 0;
         for (int k = 0; k < 60 && i < 10; k++) begin
            out_ready = !(k >= 5 && k < 10);
            in_valid = 1'b1;
            in_x = 11'(10 + i);
            in_y = 11'(20 + 3 * i);
            @(negedge clk);
            if (k == 5) begin
               chk("bp_in_ready_low", 32'(in_ready), 32'd0);
               chk("bp_out_valid", 32'(out_valid), 32'd1);
            end
            if (k >= 5 && k < 10 && q.size() != 0) begin
               chk("bp_hold_valid", 32'(out_valid), 32'd1);
               chk("bp_hold_x", 32'(src_x), q[0].sx);
               chk("bp_hold_y", 32'(src_y), q[0].sy);
            end
            if (in_ready) begin
               q.push_back(model(10 + i, 20 + 3 * i, coef_ang));
               i++;
            end
            @(posedge clk); #1;
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
      end
      drain();
      chk("bp_count", 32'(pop_cyc.size()), 32'd10);

      // out-of-range angle is ignored
      set_angle(400);

      // angle change with beats in flight
      set_angle(0);
      send(300, 200);
      send(400, 260);
      set_angle(45);
      drain();

      // frame_start in the same cycle as a beat: beat keeps the old angle
      frame_start = 1'b1;
      angle_in = 10'd0;
      in_valid = 1'b1;
      in_x = 11'd200;
      in_y = 11'd100;
      @(negedge clk);
      chk("fs_same_in_ready", 32'(in_ready), 32'd1);
      q.push_back(model(200, 100, coef_ang));
      @(posedge clk); #1;
      frame_start = 1'b0;
      in_valid = 1'b0;
      @(posedge clk); #1;
      coef_ang = 0;
      chk("fs_same_cos_angle", 32'(cos_angle), 32'd0);
      drain();

      // reset with three beats in flight
      set_angle(90);
      send(50, 60);
      send(51, 61);
      send(52, 62);
      chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_src_x", 32'(src_x), 32'd0);
      chk("mid_rst_inside", 32'(src_inside), 32'd0);
      q.delete();
      coef_ang = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("post_rst_no_out", 32'(out_valid), 32'd0);
      end
      chk("post_rst_cos_angle", 32'(cos_angle), 32'd0);
      chk("post_rst_sin_angle", 32'(sin_angle), 32'd270);
      @(posedge clk); #1;
      send(123, 45);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
